// File: rtl/fetch_unit_pkg.sv
// Shared pipeline package for the fetch stage.
// Contents:
//   - default widths for the PC, the instruction word and the imem word address
//   - the halt encoding and the NOP value that IF/ID loads on bubbles
//   - the fetch FSM state encoding
package fetch_unit_pkg;

    localparam int NB_PC_DEF    = 32;
    localparam int NB_INSTR_DEF = 32;
    localparam int NB_ADDR_DEF  = 6;

    localparam logic [31:0] HALT_INSTR_DEF = 32'hFFFF_FFFF;
    localparam logic [31:0] NOP_INSTR      = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register.
// Ports:
//   clk, rst    clock, asynchronous active-low reset
//   load        capture instr_d / pc4_d and mark the entry valid
//   flush       load a NOP bubble (valid 0); pc4 is left unchanged
//   instr_d     instruction fetched this cycle
//   pc4_d       PC+4 of the fetched instruction
//   instr_q     latched instruction
//   pc4_q       latched PC+4
//   valid_q     latched entry is a real instruction
// flush has priority over load; with neither asserted the register holds.
module if_id_reg
    import fetch_unit_pkg::*;
#(
    parameter int NB_PC    = NB_PC_DEF,
    parameter int NB_INSTR = NB_INSTR_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic                flush,
    input  logic [NB_INSTR-1:0] instr_d,
    input  logic [NB_PC-1:0]    pc4_d,
    output logic [NB_INSTR-1:0] instr_q,
    output logic [NB_PC-1:0]    pc4_q,
    output logic                valid_q
);

    logic [NB_INSTR-1:0] instr_p1;
    logic [NB_PC-1:0]    pc4_p1;
    logic                vld_p1;

    // IF -> ID boundary
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_p1 <= '0;
            pc4_p1   <= '0;
            vld_p1   <= 1'b0;
        end else if (flush) begin
            instr_p1 <= NB_INSTR'(NOP_INSTR);
            vld_p1   <= 1'b0;
        end else if (load) begin
            instr_p1 <= instr_d;
            pc4_p1   <= pc4_d;
            vld_p1   <= 1'b1;
        end
    end

    assign instr_q = instr_p1;
    assign pc4_q   = pc4_p1;
    assign valid_q = vld_p1;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, run/step/halt FSM and the IF/ID register.
// Ports:
//   clk, rst         clock, asynchronous active-low reset
//   i_start          one-cycle pulse, leaves IDLE
//   i_step_mode      1 = advance only on cycles where i_step is high
//   i_step           advance request in step mode (level sampled)
//   i_stall          hazard stall from ID: hold PC and IF/ID
//   i_redirect       taken branch/jump, load i_redirect_pc
//   i_redirect_pc    redirect target (byte address)
//   o_imem_addr      imem word address, pc[NB_ADDR+1:2]
//   i_instruction    imem read data, combinational from o_imem_addr
//   o_pc             current PC
//   o_ifid_instr     IF/ID instruction
//   o_ifid_pc4       IF/ID PC+4
//   o_ifid_valid     IF/ID holds a real instruction
//   o_halted         fetch stopped on the halt encoding
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                  NB_PC      = NB_PC_DEF,
    parameter int                  NB_INSTR   = NB_INSTR_DEF,
    parameter int                  NB_ADDR    = NB_ADDR_DEF,
    parameter logic [NB_INSTR-1:0] HALT_INSTR = NB_INSTR'(HALT_INSTR_DEF)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_start,
    input  logic                i_step_mode,
    input  logic                i_step,
    input  logic                i_stall,
    input  logic                i_redirect,
    input  logic [NB_PC-1:0]    i_redirect_pc,
    output logic [NB_ADDR-1:0]  o_imem_addr,
    input  logic [NB_INSTR-1:0] i_instruction,
    output logic [NB_PC-1:0]    o_pc,
    output logic [NB_INSTR-1:0] o_ifid_instr,
    output logic [NB_PC-1:0]    o_ifid_pc4,
    output logic                o_ifid_valid,
    output logic                o_halted
);

    fetch_state_t     state, state_nxt;
    logic [NB_PC-1:0] pc_p0, pc_nxt;
    logic [NB_PC-1:0] pc_plus4;
    logic             advance;
    logic             ifid_load;
    logic             ifid_flush;

    assign pc_plus4 = pc_p0 + NB_PC'(4);
    assign advance  = (state == ST_RUN) && (!i_step_mode || i_step);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // PC stage (p0): the address presented to instruction memory
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_p0 <= '0;
        end else begin
            pc_p0 <= pc_nxt;
        end
    end

    // Non-advancing cycles bubble IF/ID so an instruction is never issued twice.
    // Within an advancing cycle: redirect > stall > sequential fetch. A halt
    // fetch loads IF/ID normally but freezes the PC on the halt word.
    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc_p0;
        ifid_load  = 1'b0;
        ifid_flush = 1'b1;
        case (state)
            ST_IDLE: begin
                if (i_start) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (advance) begin
                    if (i_redirect) begin
                        pc_nxt = i_redirect_pc;
                    end else if (i_stall) begin
                        ifid_flush = 1'b0;
                    end else begin
                        ifid_flush = 1'b0;
                        ifid_load  = 1'b1;
                        if (i_instruction == HALT_INSTR) begin
                            state_nxt = ST_HALTED;
                        end else begin
                            pc_nxt = pc_plus4;
                        end
                    end
                end
            end
            ST_HALTED: begin
                state_nxt = ST_HALTED;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    if_id_reg #(
        .NB_PC    (NB_PC),
        .NB_INSTR (NB_INSTR)
    ) u_if_id_reg (
        .clk     (clk),
        .rst     (rst),
        .load    (ifid_load),
        .flush   (ifid_flush),
        .instr_d (i_instruction),
        .pc4_d   (pc_plus4),
        .instr_q (o_ifid_instr),
        .pc4_q   (o_ifid_pc4),
        .valid_q (o_ifid_valid)
    );

    // Low two PC bits are byte offsets; the word address wraps with the slice.
    assign o_imem_addr = pc_p0[NB_ADDR+1:2];
    assign o_pc        = pc_p0;
    assign o_halted    = (state == ST_HALTED);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit with a 64-word combinational instruction memory.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        i_start;
    logic        i_step_mode;
    logic        i_step;
    logic        i_stall;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic [5:0]  o_imem_addr;
    logic [31:0] i_instruction;
    logic [31:0] o_pc;
    logic [31:0] o_ifid_instr;
    logic [31:0] o_ifid_pc4;
    logic        o_ifid_valid;
    logic        o_halted;

    logic [31:0] mem [64];

    int n_tests = 0;
    int n_fail  = 0;

    fetch_unit dut (
        .clk           (clk),
        .rst           (rst),
        .i_start       (i_start),
        .i_step_mode   (i_step_mode),
        .i_step        (i_step),
        .i_stall       (i_stall),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .o_imem_addr   (o_imem_addr),
        .i_instruction (i_instruction),
        .o_pc          (o_pc),
        .o_ifid_instr  (o_ifid_instr),
        .o_ifid_pc4    (o_ifid_pc4),
        .o_ifid_valid  (o_ifid_valid),
        .o_halted      (o_halted)
    );

    assign i_instruction = mem[o_imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_pc"},    o_pc, 32'h0);
        chk({tag, "_instr"}, o_ifid_instr, 32'h0);
        chk({tag, "_pc4"},   o_ifid_pc4, 32'h0);
        chk({tag, "_vld"},   {31'h0, o_ifid_valid}, 32'h0);
        chk({tag, "_halt"},  {31'h0, o_halted}, 32'h0);
        chk({tag, "_addr"},  {26'h0, o_imem_addr}, 32'h0);
    endtask

    // assert reset between clock edges and check it takes effect without an edge
    task automatic async_reset(input string tag);
        #2;
        rst = 1'b0;
        #1;
        chk_reset(tag);
        tick();
        rst = 1'b1;
    endtask

    task automatic start_run();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    initial begin
        int n_vld;
        for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + i;
        mem[0] = 32'h11;
        mem[1] = 32'h22;
        mem[2] = 32'h33;
        mem[3] = 32'h44;
        mem[4] = 32'h55;
        mem[5] = 32'hFFFF_FFFF;

        rst           = 1'b0;
        i_start       = 1'b0;
        i_step_mode   = 1'b0;
        i_step        = 1'b0;
        i_stall       = 1'b0;
        i_redirect    = 1'b0;
        i_redirect_pc = 32'h0;

        #12;
        chk_reset("por");
        tick();
        rst = 1'b1;

        // ---- sequential fetch of words 0..2
        tick();
        chk("idle_pc", o_pc, 32'h0);
        start_run();
        tick();
        chk("seq0_instr", o_ifid_instr, 32'h11);
        chk("seq0_pc4",   o_ifid_pc4, 32'h4);
        chk("seq0_vld",   {31'h0, o_ifid_valid}, 32'h1);
        tick();
        chk("seq1_instr", o_ifid_instr, 32'h22);
        chk("seq1_pc4",   o_ifid_pc4, 32'h8);
        tick();
        chk("seq2_instr", o_ifid_instr, 32'h33);
        chk("seq2_pc4",   o_ifid_pc4, 32'hC);
        chk("seq2_pc",    o_pc, 32'hC);
        async_reset("rst_run");

        // ---- stall, redirect over stall, halt
        start_run();
        tick();
        tick();
        chk("pre_stall_pc", o_pc, 32'h8);
        i_stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("stall_pc",    o_pc, 32'h8);
            chk("stall_instr", o_ifid_instr, 32'h22);
            chk("stall_pc4",   o_ifid_pc4, 32'h8);
            chk("stall_vld",   {31'h0, o_ifid_valid}, 32'h1);
        end
        i_stall = 1'b0;
        tick();
        chk("resume_instr", o_ifid_instr, 32'h33);
        chk("resume_pc",    o_pc, 32'hC);

        i_redirect    = 1'b1;
        i_redirect_pc = 32'h20;
        i_stall       = 1'b1;
        tick();
        i_redirect = 1'b0;
        i_stall    = 1'b0;
        chk("redir_pc",    o_pc, 32'h20);
        chk("redir_vld",   {31'h0, o_ifid_valid}, 32'h0);
        chk("redir_instr", o_ifid_instr, 32'h0);
        chk("redir_pc4",   o_ifid_pc4, 32'hC);
        tick();
        chk("post_redir_instr", o_ifid_instr, 32'h1000_0008);
        chk("post_redir_pc4",   o_ifid_pc4, 32'h24);

        i_redirect    = 1'b1;
        i_redirect_pc = 32'h10;
        tick();
        i_redirect = 1'b0;
        tick();
        chk("w4_instr", o_ifid_instr, 32'h55);
        chk("w4_pc",    o_pc, 32'h14);
        i_stall = 1'b1;
        tick();
        i_stall = 1'b0;
        chk("stall_halt_halted", {31'h0, o_halted}, 32'h0);
        chk("stall_halt_instr",  o_ifid_instr, 32'h55);
        tick();
        chk("halt_instr",  o_ifid_instr, 32'hFFFF_FFFF);
        chk("halt_vld",    {31'h0, o_ifid_valid}, 32'h1);
        chk("halt_pc4",    o_ifid_pc4, 32'h18);
        chk("halt_pc",     o_pc, 32'h14);
        chk("halt_flag",   {31'h0, o_halted}, 32'h1);
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h40;
        tick();
        i_redirect = 1'b0;
        chk("halted_vld",   {31'h0, o_ifid_valid}, 32'h0);
        chk("halted_instr", o_ifid_instr, 32'h0);
        chk("halted_pc",    o_pc, 32'h14);
        chk("halted_addr",  {26'h0, o_imem_addr}, 32'h5);
        chk("halted_flag",  {31'h0, o_halted}, 32'h1);
        async_reset("rst_halt");

        // ---- step mode
        i_step_mode = 1'b1;
        start_run();
        n_vld = 0;
        for (int c = 0; c < 10; c++) begin
            i_step = (c == 1 || c == 5);
            tick();
            if (o_ifid_valid) n_vld++;
            if (c == 1) begin
                chk("step1_instr", o_ifid_instr, 32'h11);
                chk("step1_pc",    o_pc, 32'h4);
            end
        end
        i_step = 1'b0;
        chk("step_loads", n_vld, 32'd2);
        chk("step_pc",    o_pc, 32'h8);
        i_step = 1'b1;
        tick();
        tick();
        tick();
        i_step = 1'b0;
        chk("level_pc",    o_pc, 32'h14);
        chk("level_instr", o_ifid_instr, 32'h55);
        chk("level_halt",  {31'h0, o_halted}, 32'h0);
        tick();
        chk("level_idle_vld", {31'h0, o_ifid_valid}, 32'h0);
        async_reset("rst_step");

        // ---- address and PC wrap, unaligned redirect
        i_step_mode = 1'b0;
        start_run();
        i_redirect    = 1'b1;
        i_redirect_pc = 32'hFC;
        tick();
        i_redirect = 1'b0;
        chk("fc_addr", {26'h0, o_imem_addr}, 32'd63);
        tick();
        chk("fc_instr", o_ifid_instr, 32'h1000_003F);
        chk("fc_pc",    o_pc, 32'h100);
        chk("fc_waddr", {26'h0, o_imem_addr}, 32'd0);
        chk("fc_pc4",   o_ifid_pc4, 32'h100);
        i_redirect    = 1'b1;
        i_redirect_pc = 32'hFFFF_FFFC;
        tick();
        i_redirect = 1'b0;
        chk("top_addr", {26'h0, o_imem_addr}, 32'd63);
        tick();
        chk("top_pc",    o_pc, 32'h0);
        chk("top_pc4",   o_ifid_pc4, 32'h0);
        chk("top_instr", o_ifid_instr, 32'h1000_003F);
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h23;
        tick();
        i_redirect = 1'b0;
        chk("unal_pc",   o_pc, 32'h23);
        chk("unal_addr", {26'h0, o_imem_addr}, 32'd8);
        tick();
        chk("unal_instr", o_ifid_instr, 32'h1000_0008);
        chk("unal_pc4",   o_ifid_pc4, 32'h27);
        async_reset("rst_wrap");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter NB_PC, default 32, program-counter width in bits (byte address).
REQ-002 SHALL have parameter NB_INSTR, default 32, instruction width.
REQ-003 SHALL have parameter NB_ADDR, default 6, instruction-memory word-address width.
REQ-004 SHALL have parameter HALT_INSTR, default 32'hFFFF_FFFF, halt encoding.
REQ-005 SHALL have one clock and an asynchronous, active-low reset; ports listed below.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst  input  1  asynchronous active-low reset.
REQ-008 i_start  input  1  one-cycle pulse; leaves IDLE.
REQ-009 i_step_mode  input  1  1 = advance only on i_step pulses.
REQ-010 i_step  input  1  single-cycle advance request in step mode.
REQ-011 i_stall  input  1  hazard stall from ID; hold PC and IF/ID.
REQ-012 i_redirect  input  1  taken branch/jump this cycle.
REQ-013 i_redirect_pc  input  NB_PC  redirect target.
REQ-014 o_imem_addr  output  NB_ADDR  word address to instruction memory: pc[NB_ADDR+1:2].
REQ-015 i_instruction  input  NB_INSTR  instruction memory read data, combinational from o_imem_addr.
REQ-016 o_pc  output  NB_PC  current PC.
REQ-017 o_ifid_instr  output  NB_INSTR  IF/ID latched instruction.
REQ-018 o_ifid_pc4  output  NB_PC  IF/ID latched PC+4.
REQ-019 o_ifid_valid  output  1  IF/ID holds a real instruction.
REQ-020 o_halted  output  1  fetch stopped on HALT_INSTR.

Function
REQ-021 FSM states SHALL be IDLE, RUN, HALTED; reset enters IDLE.
REQ-022 IDLE -> RUN on i_start; RUN -> HALTED when an advancing cycle fetches i_instruction == HALT_INSTR; HALTED exits only via reset.
REQ-023 An advancing cycle SHALL be: state RUN and (i_step_mode==0 or i_step==1).
REQ-024 Per advancing cycle, priority SHALL be: i_redirect > i_stall > sequential.
REQ-025 Redirect: pc <= i_redirect_pc; IF/ID loads instr 0 (NOP), valid 0, pc4 unchanged; overrides a simultaneous i_stall.
REQ-026 Stall (no redirect): pc and all IF/ID outputs hold.
REQ-027 Sequential: pc <= pc+4; IF/ID <= {i_instruction, pc+4, valid 1}.
REQ-028 Halt fetch: IF/ID loads HALT_INSTR with valid 1, pc holds, o_halted asserts next cycle; a simultaneous redirect or stall takes priority and no halt occurs.
REQ-029 Non-advancing cycles (IDLE, HALTED, step mode without i_step) SHALL hold pc; IF/ID loads NOP with valid 0, so each instruction issues exactly once.
REQ-030 pc+4 SHALL wrap modulo 2^NB_PC; o_imem_addr wraps modulo 2^NB_ADDR words (word 63 -> word 0).
REQ-031 pc[1:0] of i_redirect_pc SHALL be ignored for addressing; o_pc reports the value as loaded.
REQ-032 Fetch latency: instruction at o_pc appears on o_ifid_instr one cycle after an advancing cycle.
REQ-033 i_step held high for N cycles SHALL advance N times (level, not edge, sampled).

Reset
REQ-034 rst low SHALL immediately set pc=0, state IDLE, o_ifid_instr=0, o_ifid_pc4=0, o_ifid_valid=0, o_halted=0, regardless of clk.
REQ-035 Reset asserted mid-RUN or in HALTED SHALL discard all IF/ID contents; first fetch after release is address 0 after i_start.

Structure
REQ-036 State encoding, HALT_INSTR, NOP value and default widths SHALL live in the shared pipeline package.
REQ-037 The IF/ID register SHALL be a separate sub-module if_id_reg (load, flush, hold controls); the PC/FSM remains in fetch_unit.

Verification
REQ-038 Reset, i_start, memory words 0..3 = 0x11,0x22,0x33,0x44 -> o_ifid_instr 0x11,0x22,0x33 on consecutive cycles, o_ifid_pc4 4,8,12.
REQ-039 i_stall high 3 cycles at pc=8 -> o_pc stays 8, IF/ID holds 0x22/pc4 8 for 3 cycles, then resumes with 0x33.
REQ-040 i_redirect=1, i_redirect_pc=0x20 with i_stall=1 -> next o_pc=0x20, o_ifid_valid=0, instr 0.
REQ-041 Word 5 = 0xFFFF_FFFF -> o_ifid_instr=HALT_INSTR once, o_halted=1, o_pc frozen at 0x14, subsequent valid=0.
REQ-042 i_step_mode=1, two i_step pulses 4 cycles apart -> exactly two valid IF/ID loads, pc 0 -> 4 -> 8.
REQ-043 pc=0xFC sequential advance -> o_imem_addr 63 then 0; rst pulsed low mid-run -> all outputs 0 asynchronously.
